// File: rtl/puf_test_ctrl.sv
// PUF characterisation sequencer: feeds challenges, streams response bits to the
// statistical tester, accumulates saturating per-test pass counts and stores them to RAM.
module puf_test_ctrl #(
    parameter int N_CB           = 64,
    parameter int N_TESTS        = 8,
    parameter int BITS_PER_ROUND = 20000,
    parameter int N_ROUNDS       = 255,
    parameter int CNT_W          = 8,
    parameter int ADDR_W         = 13,
    parameter int BASE_ADDR      = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [N_CB-1:0]     chal_in_i,
    output logic [N_CB-1:0]     chal_out_o,
    input  logic                resp_valid_i,
    input  logic                resp_i,
    output logic                test_clr_o,
    output logic                test_en_o,
    output logic                test_bit_o,
    input  logic                res_valid_i,
    input  logic [N_TESTS-1:0]  test_result_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_waddr_o,
    output logic [CNT_W-1:0]    mem_din_o,
    output logic                busy_o,
    output logic                done_o
);

    // state      | meaning
    // S_IDLE     | waiting for start after reset
    // S_CLR      | one-cycle tester clear, new challenge latched
    // S_RUN      | streaming accepted response bits to the tester
    // S_WAIT_RES | round complete, waiting for tester flags
    // S_ACCUM    | add captured flags into pass counters
    // S_STORE    | one result word written per cycle
    // S_DONE     | run finished, counts held until next start
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_WAIT_RES, S_ACCUM, S_STORE, S_DONE
    } state_t;

    localparam int BIT_W = $clog2(BITS_PER_ROUND);
    localparam int RND_W = $clog2(N_ROUNDS + 1);
    localparam int IDX_W = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BITS_PER_ROUND - 1);
    localparam logic [RND_W-1:0]  RND_LAST = RND_W'(N_ROUNDS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_TESTS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_q;
    logic [RND_W-1:0]     rnd_q;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [N_TESTS-1:0]   res_q;
    logic [CNT_W-1:0]     cnt_q [N_TESTS];
    logic [CNT_W-1:0]     cnt_d [N_TESTS];
    logic [N_CB-1:0]      chal_q;
    logic                 test_en_q, test_bit_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_waddr_q;
    logic [CNT_W-1:0]     mem_din_q;
    logic                 res_accept;

    // Flags arriving alongside the final strobe predate the tester seeing that bit.
    assign res_accept = res_valid_i && !test_en_q;
    assign idx_nxt    = idx_q + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < N_TESTS; i++) begin
            cnt_d[i] = (res_q[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = S_CLR;
            S_CLR:          state_d = S_RUN;
            S_RUN:          if (resp_valid_i && bit_q == BIT_LAST) state_d = S_WAIT_RES;
            S_WAIT_RES:     if (res_accept) state_d = S_ACCUM;
            S_ACCUM:        state_d = (rnd_q == RND_LAST) ? S_STORE : S_CLR;
            S_STORE:        if (idx_q == IDX_LAST) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        test_clr_o = (state_q == S_CLR);
        busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o     = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_q       <= '0;
            rnd_q       <= '0;
            idx_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '{default: '0};
            chal_q      <= '0;
            test_en_q   <= 1'b0;
            test_bit_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_din_q   <= '0;
        end else begin
            test_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        cnt_q <= '{default: '0};
                        rnd_q <= '0;
                    end
                end
                S_CLR: begin
                    bit_q  <= '0;
                    chal_q <= chal_in_i;
                end
                S_RUN: begin
                    if (resp_valid_i) begin
                        test_bit_q <= resp_i;
                        test_en_q  <= 1'b1;
                        chal_q     <= chal_in_i;
                        bit_q      <= bit_q + BIT_W'(1);
                    end
                end
                S_WAIT_RES: begin
                    if (res_accept) res_q <= test_result_i;
                end
                S_ACCUM: begin
                    cnt_q <= cnt_d;
                    rnd_q <= rnd_q + RND_W'(1);
                    // First word is loaded here so writes line up with the STORE cycles.
                    if (rnd_q == RND_LAST) begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= BASE;
                        mem_din_q   <= cnt_d[0];
                        idx_q       <= '0;
                    end
                end
                S_STORE: begin
                    if (idx_q == IDX_LAST) begin
                        mem_we_q <= 1'b0;
                    end else begin
                        idx_q       <= idx_nxt;
                        mem_waddr_q <= mem_waddr_q + ADDR_W'(1);
                        mem_din_q   <= cnt_q[idx_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

    assign chal_out_o  = chal_q;
    assign test_en_o   = test_en_q;
    assign test_bit_o  = test_bit_q;
    assign mem_we_o    = mem_we_q;
    assign mem_waddr_o = mem_waddr_q;
    assign mem_din_o   = mem_din_q;

endmodule

// File: tb/tb_puf_test_ctrl.sv
// Bench for puf_test_ctrl: random stimulus against a run-level model, plus literal result checks.
module tb_puf_test_ctrl;
    localparam int NCB = 16, NT = 8, BPR = 4, NR = 3, CW = 8, AW = 13, BASE = 16;
    localparam int NR_B = 5, CW_B = 2;
    localparam int M_IDLE = 0, M_CLR = 1, M_RUN = 2, M_WAIT = 3, M_ACC = 4, M_STORE = 5, M_DONE = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start, rv, resp, res_valid;
    logic [NCB-1:0] chal_in;
    logic [NT-1:0] tres;
    logic [NCB-1:0] chal_out;
    logic tclr, ten, tbit, we, busy, done;
    logic [AW-1:0] waddr;
    logic [CW-1:0] din;

    logic start_b, rv_b, resp_b, res_valid_b;
    logic [NCB-1:0] chal_in_b, chal_out_b;
    logic [NT-1:0] tres_b;
    logic tclr_b, ten_b, tbit_b, we_b, busy_b, done_b;
    logic [AW-1:0] waddr_b;
    logic [CW_B-1:0] din_b;

    puf_test_ctrl #(.N_CB(NCB), .N_TESTS(NT), .BITS_PER_ROUND(BPR), .N_ROUNDS(NR),
                    .CNT_W(CW), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .chal_in_i(chal_in), .chal_out_o(chal_out),
        .resp_valid_i(rv), .resp_i(resp), .test_clr_o(tclr), .test_en_o(ten), .test_bit_o(tbit),
        .res_valid_i(res_valid), .test_result_i(tres), .mem_we_o(we), .mem_waddr_o(waddr),
        .mem_din_o(din), .busy_o(busy), .done_o(done));

    puf_test_ctrl #(.N_CB(NCB), .N_TESTS(NT), .BITS_PER_ROUND(BPR), .N_ROUNDS(NR_B),
                    .CNT_W(CW_B), .ADDR_W(AW), .BASE_ADDR(BASE)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .chal_in_i(chal_in_b), .chal_out_o(chal_out_b),
        .resp_valid_i(rv_b), .resp_i(resp_b), .test_clr_o(tclr_b), .test_en_o(ten_b), .test_bit_o(tbit_b),
        .res_valid_i(res_valid_b), .test_result_i(tres_b), .mem_we_o(we_b), .mem_waddr_o(waddr_b),
        .mem_din_o(din_b), .busy_o(busy_b), .done_o(done_b));

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus driver ----------------
    int mode = 0, cyc = 0, pidx = 0;
    logic [3:0] pat = 4'b1101;
    always @(negedge clk) begin
        cyc++;
        chal_in = NCB'($urandom);
        case (mode)
            0: begin rv = 1'b1; resp = 1'($urandom); res_valid = 1'b1; tres = 8'hA5; end
            1: begin
                rv = ~rv;
                resp = pat[pidx];
                if (rv) pidx = (pidx + 1) % 4;
                res_valid = 1'b1;
                tres = 8'h3C;
            end
            2: begin rv = 1'b1; resp = 1'($urandom); res_valid = (cyc % 8 == 0); tres = NT'($urandom); end
            default: begin
                rv = 1'($urandom_range(0, 1));
                resp = 1'($urandom);
                res_valid = ($urandom_range(0, 3) == 0);
                tres = NT'($urandom);
            end
        endcase
    end

    // ---------------- behavioural model (run-level bookkeeping) ----------------
    int ph = M_IDLE, bits = 0, rounds = 0, widx = 0;
    int sums [NT];
    logic [NT-1:0] cap = '0;
    logic e_ten = 1'b0, e_tbit = 1'b0, old_ten;
    logic [NCB-1:0] e_chal = '0;

    function automatic logic [CW-1:0] sat(input int v);
        return (v > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = M_IDLE; e_ten = 1'b0; e_tbit = 1'b0; e_chal = '0;
            bits = 0; rounds = 0; widx = 0;
            foreach (sums[i]) sums[i] = 0;
        end else begin
            old_ten = e_ten;
            e_ten = 1'b0;
            case (ph)
                M_IDLE, M_DONE: if (start) begin
                    ph = M_CLR; rounds = 0;
                    foreach (sums[i]) sums[i] = 0;
                end
                M_CLR: begin bits = 0; e_chal = chal_in; ph = M_RUN; end
                M_RUN: if (rv) begin
                    e_tbit = resp; e_ten = 1'b1; e_chal = chal_in; bits++;
                    if (bits == BPR) ph = M_WAIT;
                end
                M_WAIT: if (res_valid && !old_ten) begin cap = tres; ph = M_ACC; end
                M_ACC: begin
                    foreach (sums[i]) sums[i] += int'(cap[i]);
                    rounds++;
                    if (rounds == NR) begin ph = M_STORE; widx = 0; end
                    else ph = M_CLR;
                end
                M_STORE: begin widx++; if (widx == NT) ph = M_DONE; end
                default: ph = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int clr_cnt = 0, en_cnt = 0, wr_cnt = 0, wr_b = 0;
    logic [CW-1:0] mem [int];
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_din;
    logic e_busy, e_done, e_we, bad;

    always @(negedge clk) begin
        if (!rst) begin
            e_busy = (ph != M_IDLE) && (ph != M_DONE);
            e_done = (ph == M_DONE);
            e_we   = (ph == M_STORE);
            e_addr = AW'(BASE + widx);
            e_din  = (ph == M_STORE) ? sat(sums[widx]) : '0;
            bad = (tclr !== (ph == M_CLR)) || (ten !== e_ten) || (tbit !== e_tbit) ||
                  (chal_out !== e_chal) || (busy !== e_busy) || (done !== e_done) || (we !== e_we) ||
                  (e_we && ((waddr !== e_addr) || (din !== e_din)));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cycle t=%0t got/exp clr %b/%b en %b/%b bit %b/%b chal %h/%h busy %b/%b done %b/%b we %b/%b addr %h/%h din %h/%h",
                         $time, tclr, (ph == M_CLR), ten, e_ten, tbit, e_tbit, chal_out, e_chal,
                         busy, e_busy, done, e_done, we, e_we, waddr, e_addr, din, e_din);
            end
            if (tclr) clr_cnt++;
            if (ten) en_cnt++;
            if (we) begin mem[int'(waddr)] = din; wr_cnt++; end
            if (we_b) begin
                wr_b++;
                chk("sat_word", din_b, 3);
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); #1; n++; end
        chk(name, done, 1'b1);
    endtask

    task automatic run(input int m);
        mode = m;
        clr_cnt = 0; en_cnt = 0; wr_cnt = 0;
        mem.delete();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_done_low", done, 1'b0);
        repeat (5) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        wait_done("done_timeout");
        chk("done_busy_low", busy, 1'b0);
    endtask

    task automatic chk_words(input string name, input logic [NT-1:0] flags);
        chk({name, "_strobes"}, en_cnt, NR * BPR);
        chk({name, "_clrs"}, clr_cnt, NR);
        chk({name, "_writes"}, wr_cnt, NT);
        for (int i = 0; i < NT; i++) chk(name, mem[BASE + i], flags[i] ? CW'(NR) : CW'(0));
    endtask

    initial begin
        int n;
        start = 0; rv = 0; resp = 0; res_valid = 0; tres = '0; chal_in = '0;
        start_b = 0; rv_b = 1; resp_b = 0; res_valid_b = 1; tres_b = 8'hFF; chal_in_b = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {tclr, ten, tbit, we, busy, done}, 6'b0);
        chk("rst_chal", chal_out, 0);
        chk("rst_mem", {waddr, din}, 0);
        chk("rst_b_ctrl", {tclr_b, ten_b, we_b, busy_b, done_b}, 5'b0);
        rst = 1'b0;

        run(0);
        chk_words("a5_word", 8'hA5);
        run(1);
        chk_words("3c_word", 8'h3C);
        run(2);
        chk("m2_strobes", en_cnt, NR * BPR);
        repeat (4) run(3);

        @(negedge clk); #1 start_b = 1'b1;
        @(negedge clk); #1 start_b = 1'b0;
        n = 0;
        while (!done_b && n < 3000) begin @(negedge clk); #1; n++; end
        chk("sat_done", done_b, 1'b1);
        chk("sat_writes", wr_b, NT);

        mode = 0; clr_cnt = 0; en_cnt = 0; wr_cnt = 0;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        n = 0;
        while (wr_cnt < 3 && n < 3000) begin @(negedge clk); #1; n++; end
        chk("abort_reach_store", wr_cnt, 3);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {tclr, ten, tbit, we, busy, done}, 6'b0);
        chk("abort_chal", chal_out, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_no_more_writes", wr_cnt, 3);
        run(0);
        chk_words("rerun_word", 8'hA5);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
